// File: rtl/wb_burst_pkg.sv
// Shared Wishbone cycle-type constants and the burst-reader state encoding.
package wb_burst_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SPACE,
    BURST,
    GAP
  } state_e;

  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 pipelined-less burst bus bundle (32-bit data, byte address).
interface wshb_if;

  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic        ack;

  modport master (
    output cyc, stb, we, adr, sel, cti, bte, dat_ms,
    input  dat_sm, ack
  );

  modport slave (
    input  cyc, stb, we, adr, sel, cti, bte, dat_ms,
    output dat_sm, ack
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; head word is visible on dout
// only while non-empty, so a push into an empty FIFO shows up one cycle later.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_MAX);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is deliberately unreset; emptiness is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/wb_burst_reader.sv
// Reads WORDS consecutive 32-bit words over Wishbone incrementing bursts and
// queues them in an output FIFO; a burst is only launched once it fits.
//
// state      | meaning
// IDLE       | waiting for start
// WAIT_SPACE | waiting for FIFO room for the whole next burst
// BURST      | cyc/stb asserted, one word per ack
// GAP        | one idle bus cycle after the last beat
module wb_burst_reader
  import wb_burst_pkg::*;
#(
  parameter logic [31:0] BASE_ADR   = 32'h0,
  parameter int          WORDS      = 1024,
  parameter int          BURST_LEN  = 16,
  parameter int          FIFO_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  wshb_if.master      wb_m,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] beats_q, beats_d;
  logic        done_q, done_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_full;
  logic          in_burst, beat_ack, pop;
  logic [31:0]   free_slots, next_beats;

  assign in_burst   = (state_q == BURST);
  assign beat_ack   = in_burst && wb_m.ack;
  assign free_slots = 32'(FIFO_DEPTH) - 32'(fifo_count);
  assign next_beats = min_u32(rem_q, 32'(BURST_LEN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      adr_q   <= BASE_ADR;
      rem_q   <= '0;
      beats_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      beats_q <= beats_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    beats_d = beats_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT_SPACE;
          adr_d   = BASE_ADR;
          rem_d   = 32'(WORDS);
        end
      end
      WAIT_SPACE: begin
        if (!fifo_full && (free_slots >= next_beats)) begin
          beats_d = next_beats;
          state_d = BURST;
        end
      end
      BURST: begin
        if (wb_m.ack) begin
          adr_d   = adr_q + 32'd4;
          rem_d   = rem_q - 32'd1;
          beats_d = beats_q - 32'd1;
          if (beats_q == 32'd1) state_d = GAP;
        end
      end
      GAP: begin
        if (rem_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = WAIT_SPACE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb_m.cyc    = in_burst;
  assign wb_m.stb    = in_burst;
  assign wb_m.we     = 1'b0;
  assign wb_m.sel    = 4'hF;
  assign wb_m.bte    = BTE_LINEAR;
  assign wb_m.dat_ms = '0;
  assign wb_m.adr    = adr_q;
  assign wb_m.cti    = !in_burst ? CTI_CLASSIC :
                       (beats_q == 32'd1) ? CTI_EOB : CTI_INCR;

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign rd_valid = !fifo_empty;
  assign pop      = rd_valid && rd_ready;

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (beat_ack),
    .din   (wb_m.dat_sm),
    .pop   (pop),
    .dout  (rd_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_wb_burst_reader.sv
// Self-checking bench: bus-side reference model plus a data scoreboard.
module tb_wb_burst_reader;
  import wb_burst_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          WORDS = 40;
  localparam int          BL    = 16;
  localparam int          DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst, start, busy, done, rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        ack_ok, ack_alt, ack_noise;

  wshb_if wb();

  wb_burst_reader #(
    .BASE_ADR(BASE), .WORDS(WORDS), .BURST_LEN(BL), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .wb_m(wb), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {16'hD00D, a[17:2]};
  endfunction

  assign wb.ack    = (wb.cyc && wb.stb && ack_ok) || (ack_noise && !wb.cyc);
  assign wb.dat_sm = word_of(wb.adr);

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  int   m_idx, m_beat, m_bl, acks, dones;
  bit   gap_due, hold_due;
  logic [31:0] hold_adr;
  logic [2:0]  hold_cti;

  function automatic int burst_len_at(input int idx);
    return (WORDS - idx < BL) ? WORDS - idx : BL;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_beat = 0; m_bl = burst_len_at(0);
    gap_due = 0; hold_due = 0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (gap_due) begin
        check_eq("gap_cyc", {31'b0, wb.cyc}, 0);
        gap_due = 0;
      end
      if (wb.cyc && wb.stb) begin
        if (hold_due) begin
          check_eq("hold_adr", wb.adr, hold_adr);
          check_eq("hold_cti", {29'b0, wb.cti}, {29'b0, hold_cti});
        end
        if (wb.ack) begin
          check_eq("adr", wb.adr, BASE + 32'(4 * m_idx));
          check_eq("cti", {29'b0, wb.cti},
                   {29'b0, (m_beat == m_bl - 1) ? CTI_EOB : CTI_INCR});
          check_eq("ctl", {wb.dat_ms, 24'b0, wb.we, wb.sel, wb.bte},
                   {32'b0, 24'b0, 1'b0, 4'hF, 2'b00});
          m_idx++; m_beat++; acks++; hold_due = 0;
          if (m_beat == m_bl) begin
            m_beat  = 0;
            gap_due = 1;
            if (m_idx < WORDS) m_bl = burst_len_at(m_idx);
          end
        end else begin
          hold_due = 1; hold_adr = wb.adr; hold_cti = wb.cti;
        end
      end
      if (done) dones++;
      if (rd_valid && rd_ready) begin
        check_eq("q_nonempty", {31'b0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) check_eq("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    ack_ok = 1'b1;
    forever begin
      @(posedge clk);
      #1 ack_ok = ack_alt ? ~ack_ok : 1'b1;
    end
  end

  task automatic pulse_start(input bit accepted);
    @(negedge clk);
    start = 1'b1;
    if (accepted) begin
      model_reset();
      for (int i = 0; i < WORDS; i++) exp_q.push_back(word_of(BASE + 32'(4 * i)));
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int c = 0;
    int d0 = dones;
    while (dones == d0 && c < max) begin @(negedge clk); c++; end
    check_eq("done_seen", {31'b0, dones != d0}, 1);
  endtask

  task automatic drain(input int max);
    int c = 0;
    while (exp_q.size() != 0 && c < max) begin @(negedge clk); c++; end
    check_eq("drain", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  int a0, d0;

  initial begin
    rst = 1'b1; start = 1'b0; rd_ready = 1'b0;
    ack_alt = 1'b0; ack_noise = 1'b0;
    acks = 0; dones = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_cyc_stb", {30'b0, wb.cyc, wb.stb}, 0);
    check_eq("rst_busy_done", {30'b0, busy, done}, 0);
    check_eq("rst_rd_valid", {31'b0, rd_valid}, 0);
    check_eq("rst_rd_data", rd_data, 0);
    check_eq("rst_adr", wb.adr, BASE);
    check_eq("rst_cti_sel", {25'b0, wb.cti, wb.sel}, {25'b0, CTI_CLASSIC, 4'hF});
    rst = 1'b0;

    // back-to-back acks, stray acks outside cycles, start re-pulsed while busy
    rd_ready = 1'b1; ack_noise = 1'b1;
    a0 = acks; d0 = dones;
    pulse_start(1);
    repeat (8) @(negedge clk);
    check_eq("busy_mid", {31'b0, busy}, 1);
    pulse_start(0);
    wait_done(500);
    drain(100);
    repeat (4) @(negedge clk);
    check_eq("acks_A", 32'(acks - a0), WORDS);
    check_eq("dones_A", 32'(dones - d0), 1);
    check_eq("busy_end_A", {31'b0, busy}, 0);
    ack_noise = 1'b0;

    // consumer stalled: bus must stop once the FIFO cannot fit a burst
    rd_ready = 1'b0;
    a0 = acks; d0 = dones;
    pulse_start(1);
    repeat (150) @(negedge clk);
    check_eq("stall_acks", 32'(acks - a0), DEPTH);
    check_eq("stall_cyc", {31'b0, wb.cyc}, 0);
    check_eq("stall_busy_valid", {30'b0, busy, rd_valid}, 2'b11);
    rd_ready = 1'b1;
    wait_done(500);
    drain(100);
    repeat (4) @(negedge clk);
    check_eq("acks_B", 32'(acks - a0), WORDS);
    check_eq("dones_B", 32'(dones - d0), 1);

    // slave acks every other cycle
    ack_alt = 1'b1;
    a0 = acks; d0 = dones;
    pulse_start(1);
    wait_done(1000);
    drain(100);
    repeat (4) @(negedge clk);
    check_eq("acks_C", 32'(acks - a0), WORDS);
    check_eq("dones_C", 32'(dones - d0), 1);
    ack_alt = 1'b0;

    // reset during the fifth beat, then a clean restart from BASE
    a0 = acks;
    pulse_start(1);
    begin
      int c = 0;
      while (acks < a0 + 4 && c < 200) begin @(negedge clk); c++; end
    end
    check_eq("reach_beat5", 32'(acks - a0), 4);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_cyc_stb", {30'b0, wb.cyc, wb.stb}, 0);
    check_eq("rst_mid_busy_valid", {30'b0, busy, rd_valid}, 0);
    check_eq("rst_mid_rd_data", rd_data, 0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("post_rst_idle", {30'b0, busy, wb.cyc}, 0);
    a0 = acks; d0 = dones;
    pulse_start(1);
    wait_done(500);
    drain(100);
    repeat (4) @(negedge clk);
    check_eq("acks_D", 32'(acks - a0), WORDS);
    check_eq("dones_D", 32'(dones - d0), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
